// File: rtl/engine_result_port_pkg.sv
// Shared constants and FSM encoding for the engine-side result-write port.
`ifndef NUM_PROC
`define NUM_PROC 4
`endif

package engine_result_port_pkg;

   localparam int ADDR_W_DEF = 19;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/engine_result_port_if.sv
// Core-side push handshake plus the arbiter request/grant and OR-bus drive.
interface engine_result_port_if #(
   parameter int ADDR_W = engine_result_port_pkg::ADDR_W_DEF,
   parameter int DATA_W = engine_result_port_pkg::DATA_W_DEF
);
   logic              res_valid;
   logic [ADDR_W-1:0] res_addr;
   logic [DATA_W-1:0] res_data;
   logic              res_ready;
   logic              engine_req;
   logic              req_ack;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_data;

   modport master (
      output res_valid, res_addr, res_data, req_ack,
      input  res_ready, engine_req, bus_addr, bus_data
   );

   modport slave (
      input  res_valid, res_addr, res_data, req_ack,
      output res_ready, engine_req, bus_addr, bus_data
   );
endinterface

// File: rtl/engine_result_port_result_fifo.sv
// Small synchronous FIFO with occupancy count; pointers wrap naturally because DEPTH is a power of two.
module engine_result_port_result_fifo #(
   parameter int WIDTH = 27,
   parameter int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk_iCLK,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // NOTE: storage has no reset; contents are only meaningful behind count, and leaving it unreset keeps it a plain RAM.
   always_ff @(posedge clk_iCLK) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_iCLK or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/engine_result_port.sv
// Buffers finished pixel results and presents them to the result arbiter via req/ack and a zero-idle OR-bus.
module engine_result_port
   import engine_result_port_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 2
) (
   input  logic                   clk_iCLK,
   input  logic                   reset,
   engine_result_port_if.slave    rp,
   output logic                   spurious_ack,
   output logic [$clog2(DEPTH):0] fill
);
   localparam int ENTRY_W = ADDR_W + DATA_W;

   state_t               state;
   logic                 engine_req_q;
   logic                 pop;
   logic                 full;
   logic                 empty;
   logic [ENTRY_W-1:0]   head;
   logic [$clog2(DEPTH):0] count;

   assign pop = (state == ST_REQ) && rp.req_ack;

   engine_result_port_result_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_iCLK (clk_iCLK),
      .reset    (reset),
      .push     (rp.res_valid),
      .wr_data  ({rp.res_addr, rp.res_data}),
      .pop      (pop),
      .rd_data  (head),
      .count    (count),
      .full     (full),
      .empty    (empty)
   );

   // Ready depends on the registered count only, so req_ack never reaches res_ready combinationally.
   assign rp.res_ready  = !full;
   assign rp.engine_req = engine_req_q;
   assign fill          = count;
   assign rp.bus_addr   = pop ? head[ENTRY_W-1:DATA_W] : '0;
   assign rp.bus_data   = pop ? head[DATA_W-1:0]       : '0;

   always_ff @(posedge clk_iCLK or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         engine_req_q <= 1'b0;
         spurious_ack <= 1'b0;
      end else begin
         if (rp.req_ack && state != ST_REQ) spurious_ack <= 1'b1;
         case (state)
            ST_IDLE: if (!empty) begin
               state        <= ST_REQ;
               engine_req_q <= 1'b1;
            end
            ST_REQ: if (rp.req_ack) begin
               state        <= ST_DONE;
               engine_req_q <= 1'b0;
            end
            ST_DONE: if (!rp.req_ack) state <= ST_IDLE;
            default: begin
               state        <= ST_IDLE;
               engine_req_q <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_engine_result_port.sv
// Directed bench for engine_result_port with hand-computed expectations (DEPTH=2).
module tb_engine_result_port;
   logic       clk_iCLK;
   logic       reset;
   logic       spurious_ack;
   logic [1:0] fill;

   int n_checks;
   int n_fail;

   engine_result_port_if #(.ADDR_W(19), .DATA_W(8)) rp ();

   engine_result_port #(.ADDR_W(19), .DATA_W(8), .DEPTH(2)) dut (
      .clk_iCLK     (clk_iCLK),
      .reset        (reset),
      .rp           (rp),
      .spurious_ack (spurious_ack),
      .fill         (fill)
   );

   initial clk_iCLK = 1'b0;
   always #5 clk_iCLK = ~clk_iCLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_iCLK);
      #1;
   endtask

   task automatic push(input logic [18:0] a, input logic [7:0] d);
      rp.res_valid = 1'b1;
      rp.res_addr  = a;
      rp.res_data  = d;
      step();
      rp.res_valid = 1'b0;
   endtask

   // Waits (bounded) for engine_req, grants one cycle and checks the bus against the expected entry.
   task automatic grant(input string tag, input logic [18:0] a, input logic [7:0] d);
      int i;
      i = 0;
      while (!rp.engine_req && i < 20) begin
         step();
         i++;
      end
      check({tag, "_req"}, {31'd0, rp.engine_req}, 32'd1);
      rp.req_ack = 1'b1;
      #1;
      check({tag, "_addr"}, {13'd0, rp.bus_addr}, {13'd0, a});
      check({tag, "_data"}, {24'd0, rp.bus_data}, {24'd0, d});
      step();
      rp.req_ack = 1'b0;
      #1;
      check({tag, "_req_drop"}, {31'd0, rp.engine_req}, 32'd0);
      check({tag, "_bus_idle"}, {5'd0, rp.bus_addr, rp.bus_data}, 32'd0);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int low_cnt;
      int bad_req, bad_fill, bad_bus;
      n_checks     = 0;
      n_fail       = 0;
      reset        = 1'b1;
      rp.res_valid = 1'b0;
      rp.res_addr  = '0;
      rp.res_data  = '0;
      rp.req_ack   = 1'b0;
      step();
      step();
      check("rst_req",      {31'd0, rp.engine_req}, 32'd0);
      check("rst_ready",    {31'd0, rp.res_ready},  32'd1);
      check("rst_bus",      {5'd0, rp.bus_addr, rp.bus_data}, 32'd0);
      check("rst_spurious", {31'd0, spurious_ack},  32'd0);
      check("rst_fill",     {30'd0, fill},          32'd0);
      reset = 1'b0;
      step();

      // Single result: request appears one edge after the push.
      push(19'h12345, 8'h7F);
      check("t1_fill_push", {30'd0, fill}, 32'd1);
      check("t1_req_n",     {31'd0, rp.engine_req}, 32'd0);
      step();
      check("t1_req_n1",    {31'd0, rp.engine_req}, 32'd1);
      check("t1_bus_noack", {5'd0, rp.bus_addr, rp.bus_data}, 32'd0);
      grant("t1", 19'h12345, 8'h7F);
      check("t1_fill_end",  {30'd0, fill}, 32'd0);
      step();
      step();

      // Three pushes into a two-entry FIFO; third is held until the first pop.
      push(19'h00001, 8'h11);
      push(19'h00002, 8'h22);
      check("t2_fill_full", {30'd0, fill}, 32'd2);
      check("t2_not_ready", {31'd0, rp.res_ready}, 32'd0);
      rp.res_valid = 1'b1;
      rp.res_addr  = 19'h00003;
      rp.res_data  = 8'h33;
      step();
      check("t2_third_held", {30'd0, fill}, 32'd2);
      grant("t2a", 19'h00001, 8'h11);
      check("t2_fill_pop", {30'd0, fill}, 32'd1);
      step();
      rp.res_valid = 1'b0;
      check("t2_third_in", {30'd0, fill}, 32'd2);
      grant("t2b", 19'h00002, 8'h22);
      grant("t2c", 19'h00003, 8'h33);
      check("t2_fill_end", {30'd0, fill}, 32'd0);
      step();
      step();

      // Back-to-back results: request must stay low through DONE and IDLE.
      push(19'h7FFFF, 8'hA5);
      push(19'h40000, 8'h5A);
      grant("t3a", 19'h7FFFF, 8'hA5);
      low_cnt = 1;
      while (!rp.engine_req && low_cnt < 20) begin
         step();
         if (!rp.engine_req) low_cnt++;
      end
      check("t3_req_gap", low_cnt, 32'd2);
      grant("t3b", 19'h40000, 8'h5A);
      step();
      step();

      // Grant withheld 50 cycles with the core still offering a third result.
      push(19'h0ABCD, 8'h01);
      push(19'h0BCDE, 8'h02);
      rp.res_valid = 1'b1;
      rp.res_addr  = 19'h0CDEF;
      rp.res_data  = 8'h03;
      bad_req  = 0;
      bad_fill = 0;
      bad_bus  = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (rp.engine_req !== 1'b1) bad_req++;
         if (fill !== 2'd2) bad_fill++;
         if ({rp.bus_addr, rp.bus_data} !== 27'd0) bad_bus++;
      end
      check("t4_hold_req",  bad_req,  32'd0);
      check("t4_hold_fill", bad_fill, 32'd0);
      check("t4_hold_bus",  bad_bus,  32'd0);
      grant("t4a", 19'h0ABCD, 8'h01);
      step();
      rp.res_valid = 1'b0;
      grant("t4b", 19'h0BCDE, 8'h02);
      grant("t4c", 19'h0CDEF, 8'h03);
      check("t4_fill_end", {30'd0, fill}, 32'd0);
      step();
      step();
      check("t4_no_spurious", {31'd0, spurious_ack}, 32'd0);

      // Grant while idle: flagged, no pop, bus stays quiet.
      rp.req_ack = 1'b1;
      #1;
      check("t5_bus", {5'd0, rp.bus_addr, rp.bus_data}, 32'd0);
      step();
      rp.req_ack = 1'b0;
      check("t5_spurious", {31'd0, spurious_ack}, 32'd1);
      check("t5_fill",     {30'd0, fill}, 32'd0);
      step();
      step();
      check("t5_sticky",   {31'd0, spurious_ack}, 32'd1);

      // Asynchronous reset while requesting with a full FIFO.
      push(19'h11111, 8'hC1);
      push(19'h22222, 8'hC2);
      check("t6_req",  {31'd0, rp.engine_req}, 32'd1);
      check("t6_fill", {30'd0, fill}, 32'd2);
      #2;
      reset = 1'b1;
      #1;
      check("t6_req_async", {31'd0, rp.engine_req}, 32'd0);
      check("t6_fill_rst",  {30'd0, fill}, 32'd0);
      check("t6_ready_rst", {31'd0, rp.res_ready}, 32'd1);
      check("t6_spur_rst",  {31'd0, spurious_ack}, 32'd0);
      step();
      reset = 1'b0;
      step();
      step();
      check("t6_idle_req", {31'd0, rp.engine_req}, 32'd0);
      rp.req_ack = 1'b1;
      #1;
      check("t6_late_bus", {5'd0, rp.bus_addr, rp.bus_data}, 32'd0);
      step();
      rp.req_ack = 1'b0;
      check("t6_late_spur", {31'd0, spurious_ack}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
